// File: rtl/wb_queue.sv
// wb_queue: in-order writeback FIFO between the ALU/memory result paths and
// the register file's single write port. Accepts up to two results per cycle
// (mem older than ALU), drains one per cycle into registered write outputs.
// Optional forwarding lookup is built when the macro WB_FORWARD_EN is defined;
// otherwise the fwd_* outputs are tied to zero.
module wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  input  logic [AW-1:0]              mem_dest,
  input  logic [DW-1:0]              mem_data,
  output logic                       mem_ready,
  input  logic                       alu_valid,
  input  logic [AW-1:0]              alu_dest,
  input  logic [DW-1:0]              alu_data,
  output logic                       alu_ready,
  output logic                       reg_write_en,
  output logic [AW-1:0]              reg_write_dest,
  output logic [DW-1:0]              reg_write_data,
  input  logic [AW-1:0]              fwd_addr_1,
  output logic                       fwd_hit_1,
  output logic [DW-1:0]              fwd_data_1,
  input  logic [AW-1:0]              fwd_addr_2,
  output logic                       fwd_hit_2,
  output logic [DW-1:0]              fwd_data_2,
  output logic [$clog2(DEPTH):0]     wb_count,
  output logic                       wb_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] ent_dest_q [DEPTH];
  logic [AW-1:0] ent_dest_d [DEPTH];
  logic [DW-1:0] ent_data_q [DEPTH];
  logic [DW-1:0] ent_data_d [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          wen_q, wen_d;
  logic [AW-1:0] wdest_q, wdest_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic [CW-1:0] free;
  logic          mem_push;
  logic          alu_push;
  logic          pop;
  logic [PW-1:0] alu_slot;

  // Ready from registered occupancy; mem has priority for the last free slot
  always_comb begin
    free      = CW'(DEPTH) - count_q;
    mem_ready = (free >= CW'(1));
    alu_ready = (free >= CW'(2)) | ((free == CW'(1)) & ~mem_valid);
    mem_push  = mem_valid & mem_ready;
    alu_push  = alu_valid & alu_ready;
    pop       = (count_q != '0);
  end

  // Next-state for storage, pointers, count and the write-port registers
  always_comb begin
    ent_dest_d = ent_dest_q;
    ent_data_d = ent_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wen_d      = 1'b0;
    wdest_d    = wdest_q;
    wdata_d    = wdata_q;
    // ALU lands behind the mem entry when both are accepted together
    alu_slot   = wr_ptr_q + PW'(mem_push);

    if (mem_push) begin
      ent_dest_d[wr_ptr_q] = mem_dest;
      ent_data_d[wr_ptr_q] = mem_data;
    end
    if (alu_push) begin
      ent_dest_d[alu_slot] = alu_dest;
      ent_data_d[alu_slot] = alu_data;
    end
    wr_ptr_d = wr_ptr_q + PW'(mem_push) + PW'(alu_push);

    if (pop) begin
      wen_d    = 1'b1;
      wdest_d  = ent_dest_q[rd_ptr_q];
      wdata_d  = ent_data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    count_d = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  // State registers; reset discards any queued entries and same-cycle pushes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_dest_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wen_q    <= 1'b0;
      wdest_q  <= '0;
      wdata_q  <= '0;
    end else begin
      ent_dest_q <= ent_dest_d;
      ent_data_q <= ent_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wen_q      <= wen_d;
      wdest_q    <= wdest_d;
      wdata_q    <= wdata_d;
    end
  end

  assign reg_write_en   = wen_q;
  assign reg_write_dest = wdest_q;
  assign reg_write_data = wdata_q;
  assign wb_count       = count_q;
  assign wb_empty       = (count_q == '0);

`ifdef WB_FORWARD_EN
  logic [PW-1:0] fwd_idx;

  // Forwarding search: output register first, then queue oldest to youngest,
  // so later matches override earlier ones and the youngest write wins
  always_comb begin
    fwd_hit_1  = 1'b0;
    fwd_data_1 = '0;
    fwd_hit_2  = 1'b0;
    fwd_data_2 = '0;
    fwd_idx    = '0;
    if (wen_q && (wdest_q == fwd_addr_1)) begin
      fwd_hit_1  = 1'b1;
      fwd_data_1 = wdata_q;
    end
    if (wen_q && (wdest_q == fwd_addr_2)) begin
      fwd_hit_2  = 1'b1;
      fwd_data_2 = wdata_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (ent_dest_q[fwd_idx] == fwd_addr_1) begin
          fwd_hit_1  = 1'b1;
          fwd_data_1 = ent_data_q[fwd_idx];
        end
        if (ent_dest_q[fwd_idx] == fwd_addr_2) begin
          fwd_hit_2  = 1'b1;
          fwd_data_2 = ent_data_q[fwd_idx];
        end
      end
    end
  end
`else
  logic unused_fwd_addr;

  assign unused_fwd_addr = ^{fwd_addr_1, fwd_addr_2};
  assign fwd_hit_1  = 1'b0;
  assign fwd_data_1 = '0;
  assign fwd_hit_2  = 1'b0;
  assign fwd_data_2 = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (DEPTH=4, AW=3, DW=16).
// Honors WB_FORWARD_EN to pick the expected forwarding results.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int DW    = 16;

  logic          clk;
  logic          rst;
  logic          mem_valid;
  logic [AW-1:0] mem_dest;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          alu_valid;
  logic [AW-1:0] alu_dest;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          reg_write_en;
  logic [AW-1:0] reg_write_dest;
  logic [DW-1:0] reg_write_data;
  logic [AW-1:0] fwd_addr_1;
  logic          fwd_hit_1;
  logic [DW-1:0] fwd_data_1;
  logic [AW-1:0] fwd_addr_2;
  logic          fwd_hit_2;
  logic [DW-1:0] fwd_data_2;
  logic [2:0]    wb_count;
  logic          wb_empty;

  int errors = 0;
  int checks = 0;

  wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
    .fwd_addr_1(fwd_addr_1), .fwd_hit_1(fwd_hit_1), .fwd_data_1(fwd_data_1),
    .fwd_addr_2(fwd_addr_2), .fwd_hit_2(fwd_hit_2), .fwd_data_2(fwd_data_2),
    .wb_count(wb_count), .wb_empty(wb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled off the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    fwd_addr_1 = '0; fwd_addr_2 = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (wb_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", wb_count); end
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", wb_empty); end
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b%b exp=11", mem_ready, alu_ready); end
    checks++; if ({reg_write_en, reg_write_dest, reg_write_data} !== '0) begin errors++; $display("FAIL reset_wport got en=%b d=%0d v=%h exp 0", reg_write_en, reg_write_dest, reg_write_data); end
    checks++; if (fwd_hit_1 !== 1'b0 || fwd_hit_2 !== 1'b0) begin errors++; $display("FAIL reset_fwd got=%b%b exp=00", fwd_hit_1, fwd_hit_2); end
  endtask

  task automatic test_single();
    alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'hABCD;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", alu_ready); end
    step();
    idle_inputs();
    checks++; if (wb_count !== 3'd1 || reg_write_en !== 1'b0) begin errors++; $display("FAIL single_e0 got cnt=%0d en=%b exp cnt=1 en=0", wb_count, reg_write_en); end
    step();
    checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd3 || reg_write_data !== 16'hABCD) begin
      errors++; $display("FAIL single_write got en=%b d=%0d v=%h exp en=1 d=3 v=abcd", reg_write_en, reg_write_dest, reg_write_data); end
    checks++; if (wb_count !== 3'd0) begin errors++; $display("FAIL single_drained got=%0d exp=0", wb_count); end
    step();
    checks++; if (reg_write_en !== 1'b0 || reg_write_dest !== 3'd3 || reg_write_data !== 16'hABCD) begin
      errors++; $display("FAIL single_hold got en=%b d=%0d v=%h exp en=0 d=3 v=abcd", reg_write_en, reg_write_dest, reg_write_data); end
  endtask

  task automatic test_dual();
    mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'h1234;
    alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 16'h5678;
    step();
    idle_inputs();
    checks++; if (wb_count !== 3'd2) begin errors++; $display("FAIL dual_count0 got=%0d exp=2", wb_count); end
    step();
    checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd2 || reg_write_data !== 16'h1234 || wb_count !== 3'd1) begin
      errors++; $display("FAIL dual_first got en=%b d=%0d v=%h cnt=%0d exp en=1 d=2 v=1234 cnt=1", reg_write_en, reg_write_dest, reg_write_data, wb_count); end
    step();
    checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd5 || reg_write_data !== 16'h5678 || wb_count !== 3'd0) begin
      errors++; $display("FAIL dual_second got en=%b d=%0d v=%h cnt=%0d exp en=1 d=5 v=5678 cnt=0", reg_write_en, reg_write_dest, reg_write_data, wb_count); end
    step();
    checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL dual_idle got=%b exp=0", reg_write_en); end
  endtask

  // Both producers stream every cycle, holding a value until accepted.
  // Occupancy tops out at DEPTH-1: at count 3 with mem_valid high only mem
  // is taken while one entry drains, so count stays at 3.
  task automatic test_back_to_back();
    logic [2:0]  exp_cnt [6];
    logic        exp_ar  [6];
    logic [2:0]  exp_d   [9];
    logic [15:0] exp_v   [9];
    logic [2:0]  got_d   [16];
    logic [15:0] got_v   [16];
    int nw = 0;
    int mi = 0;
    int ai = 0;
    logic m_acc, a_acc;
    exp_cnt = '{3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
    exp_ar  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_d   = '{3'd1, 3'd6, 3'd1, 3'd6, 3'd1, 3'd1, 3'd1, 3'd1, 3'd6};
    exp_v   = '{16'h1000, 16'h2000, 16'h1001, 16'h2001, 16'h1002,
                16'h1003, 16'h1004, 16'h1005, 16'h2002};
    for (int c = 0; c < 6; c++) begin
      mem_valid = 1'b1; mem_dest = 3'd1; mem_data = 16'h1000 + 16'(mi);
      alu_valid = 1'b1; alu_dest = 3'd6; alu_data = 16'h2000 + 16'(ai);
      #1;
      checks++; if (mem_ready !== 1'b1 || alu_ready !== exp_ar[c]) begin
        errors++; $display("FAIL burst_ready c=%0d got m=%b a=%b exp m=1 a=%b", c, mem_ready, alu_ready, exp_ar[c]); end
      m_acc = mem_ready; a_acc = alu_ready;
      step();
      if (m_acc) mi++;
      if (a_acc) ai++;
      checks++; if (wb_count !== exp_cnt[c]) begin errors++; $display("FAIL burst_count c=%0d got=%0d exp=%0d", c, wb_count, exp_cnt[c]); end
      if (reg_write_en && nw < 16) begin got_d[nw] = reg_write_dest; got_v[nw] = reg_write_data; nw++; end
    end
    // Count is 3; with mem idle the ALU may take the last free slot
    mem_valid = 1'b0;
    alu_data = 16'h2000 + 16'(ai);
    #1;
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL last_slot_ready got m=%b a=%b exp m=1 a=1", mem_ready, alu_ready); end
    step();
    idle_inputs();
    if (reg_write_en && nw < 16) begin got_d[nw] = reg_write_dest; got_v[nw] = reg_write_data; nw++; end
    for (int c = 0; c < 10; c++) begin
      step();
      if (reg_write_en && nw < 16) begin got_d[nw] = reg_write_dest; got_v[nw] = reg_write_data; nw++; end
    end
    checks++; if (nw !== 9) begin errors++; $display("FAIL burst_nwrites got=%0d exp=9", nw); end
    for (int k = 0; k < 9; k++) begin
      if (k < nw) begin
        checks++; if (got_d[k] !== exp_d[k] || got_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL burst_order k=%0d got d=%0d v=%h exp d=%0d v=%h", k, got_d[k], got_v[k], exp_d[k], exp_v[k]); end
      end
    end
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL burst_empty got=%b exp=1", wb_empty); end
  endtask

  task automatic test_forward();
    logic        eh1 [4];
    logic [15:0] ed1 [4];
    fwd_addr_1 = 3'd4; fwd_addr_2 = 3'd6;
`ifdef WB_FORWARD_EN
    // queue both; queue younger; output reg only; nothing pending
    eh1 = '{1'b1, 1'b1, 1'b1, 1'b0};
    ed1 = '{16'h0002, 16'h0002, 16'h0002, 16'h0000};
`else
    eh1 = '{1'b0, 1'b0, 1'b0, 1'b0};
    ed1 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
    mem_valid = 1'b1; mem_dest = 3'd4; mem_data = 16'h0001;
    alu_valid = 1'b1; alu_dest = 3'd4; alu_data = 16'h0002;
    step();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      checks++; if (fwd_hit_1 !== eh1[c] || fwd_data_1 !== ed1[c]) begin
        errors++; $display("FAIL fwd_port1 c=%0d got hit=%b v=%h exp hit=%b v=%h", c, fwd_hit_1, fwd_data_1, eh1[c], ed1[c]); end
      checks++; if (fwd_hit_2 !== 1'b0 || fwd_data_2 !== 16'h0000) begin
        errors++; $display("FAIL fwd_port2 c=%0d got hit=%b v=%h exp hit=0 v=0000", c, fwd_hit_2, fwd_data_2); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    mem_valid = 1'b1; mem_dest = 3'd1; mem_data = 16'h0A0A;
    alu_valid = 1'b1; alu_dest = 3'd2; alu_data = 16'h0B0B;
    step();
    mem_dest = 3'd3; mem_data = 16'h0C0C;
    alu_dest = 3'd4; alu_data = 16'h0D0D;
    step();
    checks++; if (wb_count !== 3'd3 || reg_write_en !== 1'b1) begin errors++; $display("FAIL rstmid_pre got cnt=%0d en=%b exp cnt=3 en=1", wb_count, reg_write_en); end
    mem_dest = 3'd7; mem_data = 16'h0E0E;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    checks++; if (wb_count !== 3'd0 || wb_empty !== 1'b1) begin errors++; $display("FAIL rstmid_count got cnt=%0d empty=%b exp cnt=0 empty=1", wb_count, wb_empty); end
    checks++; if (reg_write_en !== 1'b0 || reg_write_dest !== 3'd0 || reg_write_data !== 16'h0000) begin
      errors++; $display("FAIL rstmid_wport got en=%b d=%0d v=%h exp 0", reg_write_en, reg_write_dest, reg_write_data); end
    for (int c = 0; c < 6; c++) begin
      step();
      if (reg_write_en !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL rstmid_stale got=%0d exp=0", stale); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    fwd_addr_1 = '0; fwd_addr_2 = '0;
    test_reset();
    test_single();
    test_dual();
    test_back_to_back();
    test_forward();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
